// File: rtl/ez8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ez8_pkg
// Description : Shared widths, opcode encodings and reset values for the
//               ez8 execute/writeback slice.
// Revision    : 1.0 - initial release
// ============================================================================
package ez8_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int REG_ADDR_WIDTH = 7;

    // Opcode group encodings as decoded upstream in the ALU.
    localparam int OP_WIDTH = 3;
    localparam logic [OP_WIDTH-1:0] c_op_get_put = 3'd0;
    localparam logic [OP_WIDTH-1:0] c_op_set     = 3'd1;
    localparam logic [OP_WIDTH-1:0] c_op_ret     = 3'd2;
    localparam logic [OP_WIDTH-1:0] c_op_skbc    = 3'd3;
    localparam logic [OP_WIDTH-1:0] c_op_indir   = 3'd4;
    localparam logic [OP_WIDTH-1:0] c_op_clr_com = 3'd5;

    // Reset values of architectural and control state.
    localparam logic c_rst_flag       = 1'b0;
    localparam logic c_rst_skip       = 1'b0;
    localparam logic c_rst_int_active = 1'b0;
    localparam logic c_rst_rf_we      = 1'b0;

    // Conditional update helper: take the new value only when enabled.
    function automatic logic upd_bit(input logic en, input logic nv, input logic ov);
        return en ? nv : ov;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_shadow.sv
`default_nettype none
// ============================================================================
// Module      : int_shadow
// Description : Single-level interrupt context store (accumulator, Z, C,
//               pending skip) plus the in-handler flag.
// Revision    : 1.0 - initial release
// ============================================================================
module int_shadow #(
    parameter int DATA_WIDTH = ez8_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_capture,
    input  logic                  i_restore,
    input  logic [DATA_WIDTH-1:0] i_cap_accum,
    input  logic                  i_cap_z,
    input  logic                  i_cap_c,
    input  logic                  i_cap_skip,
    output logic [DATA_WIDTH-1:0] o_sh_accum,
    output logic                  o_sh_z,
    output logic                  o_sh_c,
    output logic                  o_sh_skip,
    output logic                  o_int_active
);

    import ez8_pkg::*;

    logic [DATA_WIDTH-1:0] r_sh_accum;
    logic                  r_sh_z;
    logic                  r_sh_c;
    logic                  r_sh_skip;
    logic                  r_int_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_accum   <= '0;
            r_sh_z       <= c_rst_flag;
            r_sh_c       <= c_rst_flag;
            r_sh_skip    <= c_rst_skip;
            r_int_active <= c_rst_int_active;
        end else begin
            if (i_capture) begin
                r_sh_accum <= i_cap_accum;
                r_sh_z     <= i_cap_z;
                r_sh_c     <= i_cap_c;
                r_sh_skip  <= i_cap_skip;
            end
            // Capture and restore are exclusive by construction in the parent.
            if (i_capture) begin
                r_int_active <= 1'b1;
            end else if (i_restore) begin
                r_int_active <= 1'b0;
            end
        end
    end

    assign o_sh_accum   = r_sh_accum;
    assign o_sh_z       = r_sh_z;
    assign o_sh_c       = r_sh_c;
    assign o_sh_skip    = r_sh_skip;
    assign o_int_active = r_int_active;

endmodule
`default_nettype wire

// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
// Module      : writeback
// Description : ez8 execute/writeback stage: owns accumulator and Z/C flags,
//               registers the RF write, handles skip squash and interrupt context.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback #(
    parameter int DATA_WIDTH     = ez8_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = ez8_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic                      in_valid,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0]     result,
    input  logic                      accum_write,
    input  logic                      reg_write,
    input  logic                      z_write,
    input  logic                      zout,
    input  logic                      c_write,
    input  logic                      cout,
    input  logic                      retint,
    input  logic                      skip,
    input  logic                      int_take,
    output logic [DATA_WIDTH-1:0]     accum,
    output logic                      flag_z,
    output logic                      flag_c,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      squash,
    output logic                      int_active
);

    import ez8_pkg::*;

    logic [DATA_WIDTH-1:0]     r_accum;
    logic                      r_flag_z;
    logic                      r_flag_c;
    logic                      r_skip_pending;
    logic                      r_rf_we;
    logic [REG_ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0]     r_rf_wdata;

    logic                      w_commit;
    logic                      w_squash;
    logic                      w_restore;
    logic                      w_enter;
    logic                      w_rf_load;
    logic                      w_int_active;

    // Next state from the instruction alone (before interrupt override).
    logic [DATA_WIDTH-1:0]     w_accum_nxt;
    logic                      w_z_nxt;
    logic                      w_c_nxt;
    logic                      w_skip_nxt;

    // Final next state after entry/return handling.
    logic [DATA_WIDTH-1:0]     w_accum_fin;
    logic                      w_z_fin;
    logic                      w_c_fin;
    logic                      w_skip_fin;

    logic [DATA_WIDTH-1:0]     w_sh_accum;
    logic                      w_sh_z;
    logic                      w_sh_c;
    logic                      w_sh_skip;

    assign w_commit  = in_valid & ~stall & ~r_skip_pending;
    assign w_squash  = in_valid & ~stall & r_skip_pending;
    assign w_restore = w_commit & retint & w_int_active;
    // A committing retint beats an interrupt request in the same cycle.
    assign w_enter   = int_take & ~stall & ~w_int_active & ~(w_commit & retint);
    assign w_rf_load = w_commit & reg_write;

    always_comb begin
        w_accum_nxt = r_accum;
        w_z_nxt     = r_flag_z;
        w_c_nxt     = r_flag_c;
        w_skip_nxt  = r_skip_pending;
        if (w_commit) begin
            if (accum_write) begin
                w_accum_nxt = result;
            end
            w_z_nxt    = upd_bit(z_write, zout, r_flag_z);
            w_c_nxt    = upd_bit(c_write, cout, r_flag_c);
            w_skip_nxt = skip;
        end else if (w_squash) begin
            w_skip_nxt = 1'b0;
        end
    end

    always_comb begin
        w_accum_fin = w_accum_nxt;
        w_z_fin     = w_z_nxt;
        w_c_fin     = w_c_nxt;
        w_skip_fin  = w_skip_nxt;
        if (w_restore) begin
            w_accum_fin = w_sh_accum;
            w_z_fin     = w_sh_z;
            w_c_fin     = w_sh_c;
            w_skip_fin  = w_sh_skip;
        end else if (w_enter) begin
            w_skip_fin  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_accum        <= '0;
            r_flag_z       <= c_rst_flag;
            r_flag_c       <= c_rst_flag;
            r_skip_pending <= c_rst_skip;
        end else begin
            r_accum        <= w_accum_fin;
            r_flag_z       <= w_z_fin;
            r_flag_c       <= w_c_fin;
            r_skip_pending <= w_skip_fin;
        end
    end

    // Register-file port: one-cycle pulse, address/data held between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_we    <= c_rst_rf_we;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_rf_load;
            if (w_rf_load) begin
                r_rf_waddr <= reg_addr;
                r_rf_wdata <= result;
            end
        end
    end

    // Shadows take the pre-override next state so a same-cycle commit survives.
    int_shadow #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_int_shadow (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_capture    (w_enter),
        .i_restore    (w_restore),
        .i_cap_accum  (w_accum_nxt),
        .i_cap_z      (w_z_nxt),
        .i_cap_c      (w_c_nxt),
        .i_cap_skip   (w_skip_nxt),
        .o_sh_accum   (w_sh_accum),
        .o_sh_z       (w_sh_z),
        .o_sh_c       (w_sh_c),
        .o_sh_skip    (w_sh_skip),
        .o_int_active (w_int_active)
    );

    assign accum      = r_accum;
    assign flag_z     = r_flag_z;
    assign flag_c     = r_flag_c;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign squash     = w_squash;
    assign int_active = w_int_active;

endmodule
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback
// Description : Directed self-checking bench for the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback;

    logic       clk;
    logic       reset_n;
    logic       stall;
    logic       in_valid;
    logic [6:0] reg_addr;
    logic [7:0] result;
    logic       accum_write;
    logic       reg_write;
    logic       z_write;
    logic       zout;
    logic       c_write;
    logic       cout;
    logic       retint;
    logic       skip;
    logic       int_take;
    logic [7:0] accum;
    logic       flag_z;
    logic       flag_c;
    logic       rf_we;
    logic [6:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       squash;
    logic       int_active;

    int checks = 0;
    int errors = 0;

    writeback #(
        .DATA_WIDTH     (8),
        .REG_ADDR_WIDTH (7)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .in_valid    (in_valid),
        .reg_addr    (reg_addr),
        .result      (result),
        .accum_write (accum_write),
        .reg_write   (reg_write),
        .z_write     (z_write),
        .zout        (zout),
        .c_write     (c_write),
        .cout        (cout),
        .retint      (retint),
        .skip        (skip),
        .int_take    (int_take),
        .accum       (accum),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .squash      (squash),
        .int_active  (int_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall       = 1'b0;
        in_valid    = 1'b0;
        reg_addr    = '0;
        result      = '0;
        accum_write = 1'b0;
        reg_write   = 1'b0;
        z_write     = 1'b0;
        zout        = 1'b0;
        c_write     = 1'b0;
        cout        = 1'b0;
        retint      = 1'b0;
        skip        = 1'b0;
        int_take    = 1'b0;
    endtask

    // Drive at negedge, let the posedge commit, sample 1 time unit later.
    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        check("rst_accum", accum, 8'h00);
        check("rst_z", flag_z, 1'b0);
        check("rst_c", flag_c, 1'b0);
        check("rst_we", rf_we, 1'b0);
        check("rst_waddr", rf_waddr, 7'h00);
        check("rst_wdata", rf_wdata, 8'h00);
        check("rst_int", int_active, 1'b0);
        check("rst_squash", squash, 1'b0);

        // Accumulator and Z commit.
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        in_valid = 1'b1; result = 8'h5A; accum_write = 1'b1; z_write = 1'b1; zout = 1'b0;
        next_edge();
        check("acc_5a", accum, 8'h5A);
        check("acc_z", flag_z, 1'b0);
        check("acc_no_we", rf_we, 1'b0);

        // Register write, then a stalled cycle.
        @(negedge clk);
        idle();
        in_valid = 1'b1; reg_write = 1'b1; reg_addr = 7'h12; result = 8'h3C;
        next_edge();
        check("rf_we", rf_we, 1'b1);
        check("rf_waddr", rf_waddr, 7'h12);
        check("rf_wdata", rf_wdata, 8'h3C);
        check("rf_acc_hold", accum, 8'h5A);
        @(negedge clk);
        idle();
        stall = 1'b1; in_valid = 1'b1; reg_write = 1'b1; reg_addr = 7'h55; result = 8'h77;
        accum_write = 1'b1;
        #1;
        check("stall_squash", squash, 1'b0);
        next_edge();
        check("stall_we", rf_we, 1'b0);
        check("stall_waddr", rf_waddr, 7'h12);
        check("stall_wdata", rf_wdata, 8'h3C);
        check("stall_acc", accum, 8'h5A);

        // Skip across a bubble.
        @(negedge clk);
        idle();
        in_valid = 1'b1; skip = 1'b1;
        next_edge();
        @(negedge clk);
        idle();
        #1;
        check("skip_bubble_sq", squash, 1'b0);
        next_edge();
        @(negedge clk);
        idle();
        in_valid = 1'b1; accum_write = 1'b1; result = 8'hFF; z_write = 1'b1; zout = 1'b1;
        skip = 1'b1; reg_write = 1'b1; reg_addr = 7'h01;
        #1;
        check("skip_sq", squash, 1'b1);
        next_edge();
        check("skip_acc", accum, 8'h5A);
        check("skip_z", flag_z, 1'b0);
        check("skip_we", rf_we, 1'b0);
        @(negedge clk);
        idle();
        in_valid = 1'b1; accum_write = 1'b1; result = 8'h11; c_write = 1'b1; cout = 1'b1;
        #1;
        check("skip_cleared", squash, 1'b0);
        next_edge();
        check("acc_11", accum, 8'h11);
        check("c_1", flag_c, 1'b1);

        // Interrupt entry with same-cycle commit.
        @(negedge clk);
        idle();
        in_valid = 1'b1; accum_write = 1'b1; result = 8'h22; int_take = 1'b1;
        next_edge();
        check("ent_acc", accum, 8'h22);
        check("ent_int", int_active, 1'b1);
        @(negedge clk);
        idle();
        in_valid = 1'b1; accum_write = 1'b1; result = 8'h99; c_write = 1'b1; cout = 1'b0;
        z_write = 1'b1; zout = 1'b1;
        next_edge();
        check("hdl_acc", accum, 8'h99);
        check("hdl_c", flag_c, 1'b0);
        check("hdl_z", flag_z, 1'b1);
        // Nested request is ignored.
        @(negedge clk);
        idle();
        in_valid = 1'b1; accum_write = 1'b1; result = 8'h44; int_take = 1'b1;
        next_edge();
        check("nest_acc", accum, 8'h44);
        check("nest_int", int_active, 1'b1);
        // Retint together with int_take: restore wins, reg write still happens.
        @(negedge clk);
        idle();
        in_valid = 1'b1; retint = 1'b1; int_take = 1'b1; accum_write = 1'b1; result = 8'h55;
        reg_write = 1'b1; reg_addr = 7'h33; c_write = 1'b1; cout = 1'b0;
        next_edge();
        check("ret_acc", accum, 8'h22);
        check("ret_c", flag_c, 1'b1);
        check("ret_z", flag_z, 1'b0);
        check("ret_int", int_active, 1'b0);
        check("ret_we", rf_we, 1'b1);
        check("ret_waddr", rf_waddr, 7'h33);
        check("ret_wdata", rf_wdata, 8'h55);
        @(negedge clk);
        idle();
        next_edge();
        check("ret_int_stay", int_active, 1'b0);

        // Plain retint outside a handler.
        @(negedge clk);
        idle();
        in_valid = 1'b1; retint = 1'b1; accum_write = 1'b1; result = 8'h66;
        next_edge();
        check("plain_ret_acc", accum, 8'h66);
        check("plain_ret_int", int_active, 1'b0);

        // Pending skip is saved across the handler and restored.
        @(negedge clk);
        idle();
        in_valid = 1'b1; skip = 1'b1; int_take = 1'b1;
        next_edge();
        check("sk_ent_int", int_active, 1'b1);
        @(negedge clk);
        idle();
        in_valid = 1'b1; accum_write = 1'b1; result = 8'hA5;
        #1;
        check("sk_hdl_sq", squash, 1'b0);
        next_edge();
        check("sk_hdl_acc", accum, 8'hA5);
        @(negedge clk);
        idle();
        in_valid = 1'b1; retint = 1'b1;
        next_edge();
        check("sk_ret_acc", accum, 8'h66);
        check("sk_ret_int", int_active, 1'b0);
        @(negedge clk);
        idle();
        in_valid = 1'b1; accum_write = 1'b1; result = 8'hBB;
        #1;
        check("sk_ret_sq", squash, 1'b1);
        next_edge();
        check("sk_ret_acc2", accum, 8'h66);

        // Asynchronous reset mid-cycle with pending skip and RF write.
        @(negedge clk);
        idle();
        in_valid = 1'b1; skip = 1'b1; reg_write = 1'b1; reg_addr = 7'h7F; result = 8'hC3;
        accum_write = 1'b1; c_write = 1'b1; cout = 1'b1; int_take = 1'b1;
        next_edge();
        check("pre_rst_we", rf_we, 1'b1);
        check("pre_rst_int", int_active, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_acc", accum, 8'h00);
        check("arst_c", flag_c, 1'b0);
        check("arst_we", rf_we, 1'b0);
        check("arst_waddr", rf_waddr, 7'h00);
        check("arst_wdata", rf_wdata, 8'h00);
        check("arst_int", int_active, 1'b0);
        check("arst_sq", squash, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        in_valid = 1'b1; accum_write = 1'b1; result = 8'h12;
        #1;
        check("post_rst_sq", squash, 1'b0);
        next_edge();
        check("post_rst_acc", accum, 8'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
